scpad_head_arb: RTL
===================

// Module: scpad_head_arb
// PURPOSE
// - N-requester scratchpad head arbiter. Parametrised successor of the fixed 2-input BE>FE head mux.
// - Arbitrates NUM_REQ request channels into one registered request stream toward the write/read xbars.
// - Honours separate write/read downstream stalls. Fixed priority with anti-starvation by default.
// - Round-robin arbitration is available as a compile option.
// PARAMETERS
// - NUM_REQ      2   number of requesters; index 0 = backend (highest fixed priority), 1 = frontend
// - ADDR_W       16  scratchpad address width
// - NUM_COLS     32  columns per row; also the mask width
// - ELEM_W       16  bits per column element; DATA_W = NUM_COLS*ELEM_W
// - STARVE_LIMIT 15  wait cycles (>=1) after which a requester is promoted; CNT_W = $clog2(STARVE_LIMIT+1)
// PORTS (SRC_W = max(1,$clog2(NUM_REQ)))
// - clk        in   1               clock
// - n_rst      in   1               asynchronous active-low reset
// - req_valid  in   NUM_REQ         request present, per channel
// - req_write  in   NUM_REQ         1=write, 0=read
// - req_addr   in   NUM_REQ*ADDR_W  row address
// - req_wdata  in   NUM_REQ*DATA_W  write data (ignored for reads)
// - req_mask   in   NUM_REQ*NUM_COLS column enable mask
// - req_stall  out  NUM_REQ         channel must hold request stable
// - w_stall    in   1               write path backpressure
// - r_stall    in   1               read path backpressure
// - out_valid  out  1               registered request valid
// - out_write  out  1               registered op
// - out_src    out  SRC_W           index of originating requester
// - out_addr   out  ADDR_W          registered address
// - out_wdata  out  DATA_W          registered write data
// - out_mask   out  NUM_COLS        registered mask
// BEHAVIOUR
// - Reset (n_rst=0, async): out_valid=0, out_write=0, out_src=0, out_addr/out_wdata/out_mask=0.
//   Starvation counters=0; RR pointer=0. While n_rst=0, req_stall=req_valid.
// - Reset mid-operation: the held output is dropped. Requesters must re-present.
// - Handshake: channel i is accepted in a cycle where req_valid[i]=1 and req_stall[i]=0.
//   While stalled, the requester holds valid and payload stable.
// - out_stall = out_valid & (out_write ? w_stall : r_stall). load = ~out_valid | ~out_stall.
// - req_stall[i] = req_valid[i] & ~(grant[i] & load). This path is combinational from w_stall/r_stall.
// - At most one grant per cycle, and only when load=1. The accepted request appears on out_* at the next edge.
//   Latency is 1 cycle. Full throughput is 1 request/cycle with no stalls.
// - out_* hold unchanged while out_stall=1. When load=1 and no grant, out_valid<=0.
// - Ordering is strictly in-order through one register. A pending read waits behind a stalled write, and vice versa.
// - Fixed priority: the lowest index with req_valid wins, except that starved requesters win first.
//   Among requesters with cnt==STARVE_LIMIT, the lowest such index wins.
// - Starvation counter per channel:
//   - Cleared when req_valid=0 or the channel is accepted.
//   - Otherwise +1 per cycle, saturating at STARVE_LIMIT.
//   - Counts only while load=1, so downstream-stall cycles are not starvation.
// - Simultaneous acceptance and downstream release: if out_stall deasserts in cycle N, a new grant in N loads at edge N.
// - Grant is one-hot or zero. Granting a channel with req_valid=0 is illegal; assert in simulation.
// CONFIGURATION
// - SCPAD_HEAD_RR_EN defined:
//   - Round-robin arbitration. The search starts at rr_ptr and wraps from NUM_REQ-1 to 0.
//   - On accept of channel g: rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1. rr_ptr is unchanged without accept.
//   - Starvation counters and promotion are not compiled in.
// - SCPAD_HEAD_RR_EN undefined: fixed priority with starvation promotion, as above.
// TESTING
// - Single read on ch1, addr=0x12, no stalls -> req_stall[1]=0 that cycle; next cycle out_valid=1, out_src=1, out_addr=0x12, out_write=0.
// - ch0 and ch1 both valid, same cycle, fixed mode -> ch0 granted; req_stall[1]=1; ch1 granted the following cycle if ch0 drops valid.
// - ch0 valid continuously, ch1 valid, STARVE_LIMIT=15 -> ch1 granted after exactly 15 lost cycles, then ch0 resumes.
// - out holds a write, w_stall=1 for 4 cycles, read pending on ch1 -> out_* frozen 4 cycles; req_stall[1]=1; read emitted 1 cycle after w_stall drops.
// - n_rst pulsed low while out_valid=1 -> out_valid=0 immediately (async); counters=0; first grant after release is ch0.
// - SCPAD_HEAD_RR_EN, NUM_REQ=4, all valid -> grants 0,1,2,3,0 on consecutive cycles.

Source files
------------

// File: rtl/scpad_head_arb.sv
// Scratchpad head arbiter: NUM_REQ request channels into one registered request stage.
// Define SCPAD_HEAD_RR_EN for round-robin; default is fixed priority with starvation promotion.
module scpad_head_arb #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned NUM_COLS     = 32,
  parameter int unsigned ELEM_W       = 16,
  parameter int unsigned STARVE_LIMIT = 15,
  localparam int unsigned DATA_W      = NUM_COLS * ELEM_W,
  localparam int unsigned SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*NUM_COLS-1:0]  req_mask,
  output logic [NUM_REQ-1:0]           req_stall,
  input  logic                         w_stall,
  input  logic                         r_stall,
  output logic                         out_valid,
  output logic                         out_write,
  output logic [SRC_W-1:0]             out_src,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [DATA_W-1:0]            out_wdata,
  output logic [NUM_COLS-1:0]          out_mask
);

  logic                out_stall;
  logic                load;
  logic [NUM_REQ-1:0]  grant;
  logic [SRC_W-1:0]    gidx;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [NUM_COLS-1:0] sel_mask;

  assign out_stall = out_valid & (out_write ? w_stall : r_stall);
  assign load      = ~out_valid | ~out_stall;
  // grant is already gated by load and reset, so this also gives req_stall = req_valid in reset
  assign req_stall = req_valid & ~grant;

`ifdef SCPAD_HEAD_RR_EN
  logic [SRC_W-1:0] rr_ptr;
  int               best;
  int               dist;

  // Pick the valid channel with the smallest rotated distance from rr_ptr.
  always_comb begin
    grant = '0;
    best  = int'(NUM_REQ);
    dist  = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      dist = (i >= int'(rr_ptr)) ? i - int'(rr_ptr) : i + int'(NUM_REQ) - int'(rr_ptr);
      if (req_valid[i] && dist < best) begin
        best     = dist;
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    grant = grant & {NUM_REQ{load & n_rst}};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= (gidx == SRC_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end
`else
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]   cnt [NUM_REQ];
  logic [NUM_REQ-1:0] cand;

  // Starved channels first (lowest index), then plain lowest-index priority.
  always_comb begin
    cand = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (cand == '0 && req_valid[i] && cnt[i] == CNT_W'(STARVE_LIMIT)) cand[i] = 1'b1;
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (cand == '0 && req_valid[i]) cand[i] = 1'b1;
    end
    grant = cand & {NUM_REQ{load & n_rst}};
  end

  // Only load cycles count as lost, so downstream backpressure is not starvation.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(NUM_REQ); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!req_valid[i] || grant[i]) begin
          cnt[i] <= '0;
        end else if (load && cnt[i] != CNT_W'(STARVE_LIMIT)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    gidx      = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        gidx      = SRC_W'(i);
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_mask  = req_mask[i*NUM_COLS +: NUM_COLS];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid <= 1'b0;
      out_write <= 1'b0;
      out_src   <= '0;
      out_addr  <= '0;
      out_wdata <= '0;
      out_mask  <= '0;
    end else if (load) begin
      out_valid <= |grant;
      if (|grant) begin
        out_write <= sel_write;
        out_src   <= gidx;
        out_addr  <= sel_addr;
        out_wdata <= sel_wdata;
        out_mask  <= sel_mask;
      end
    end
  end

  grant_legal_a: assert property (@(posedge clk) disable iff (!n_rst)
    $onehot0(grant) && ((grant & ~req_valid) == '0));

endmodule
